// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, per-boundary payload layouts and the per-cycle action decode
// for the inter-stage pipeline register of the five-stage MIPS core.
package pipe_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus8;
    } fd_payload_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  dest_reg;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm_ext;
    } de_payload_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  mem_size;
        logic [4:0]  dest_reg;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } em_payload_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dest_reg;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
    } mw_payload_t;

    localparam int FD_PAYLOAD_W = $bits(fd_payload_t);
    localparam int DE_PAYLOAD_W = $bits(de_payload_t);
    localparam int EM_PAYLOAD_W = $bits(em_payload_t);
    localparam int MW_PAYLOAD_W = $bits(mw_payload_t);

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_REQ,
        ACT_CLR,
        ACT_HOLD,
        ACT_LOAD
    } stage_action_t;

    // Fixed priority: reset > exception request > flush > hold > load.
    // A bubble is never held, so hold needs a real entry blocked downstream.
    function automatic stage_action_t decode_action(
        input logic reset,
        input logic req,
        input logic clr,
        input logic held_valid,
        input logic down_ready
    );
        if (reset)
            return ACT_RESET;
        else if (req)
            return ACT_REQ;
        else if (clr)
            return ACT_CLR;
        else if (held_valid && !down_ready)
            return ACT_HOLD;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One direction of a pipeline boundary: valid/ready handshake carrying PC,
// branch-delay flag and packed payload. master drives the entry, slave accepts it.
interface pipe_stage_if #(
    parameter int PAYLOAD_W = 128
);
    logic                 valid;
    logic                 ready;
    logic [31:0]          pc;
    logic                 bd;
    logic [PAYLOAD_W-1:0] payload;

    modport master (
        output valid,
        output pc,
        output bd,
        output payload,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  bd,
        input  payload,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg_skid.sv
// One-entry skid slot: catches an entry accepted while the main register is held.
// Used by pipe_stage_reg only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_slot #(
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_unload,
    input  logic [31:0]          i_pc,
    input  logic                 i_bd,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic [31:0]          o_pc,
    output logic                 o_bd,
    output logic [PAYLOAD_W-1:0] o_payload
);
    logic                 r_valid;
    logic [31:0]          r_pc;
    logic                 r_bd;
    logic [PAYLOAD_W-1:0] r_payload;

    // Clearing wins over loading so a flush in the capture cycle drops the entry.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_bd      <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_pc      <= i_pc;
            r_bd      <= i_bd;
            r_payload <= i_payload;
        end else if (i_unload) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_pc      = r_pc;
    assign o_bd      = r_bd;
    assign o_payload = r_payload;
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with handshake, flush bubbles and exception redirect.
// Define PIPE_STAGE_SKID_EN for a one-entry skid slot with a registered in_ready.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int          PAYLOAD_W  = 128,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         clr,
    pipe_stage_if.slave  up,
    pipe_stage_if.master dn
);
    logic                 r_valid;
    logic [31:0]          r_pc;
    logic                 r_bd;
    logic [PAYLOAD_W-1:0] r_payload;

    stage_action_t        w_action;
    logic                 w_in_ready;
    logic                 w_src_valid;
    logic [31:0]          w_src_pc;
    logic                 w_src_bd;
    logic [PAYLOAD_W-1:0] w_src_payload;

    assign w_action = decode_action(reset, req, clr, r_valid, dn.ready);

`ifdef PIPE_STAGE_SKID_EN
    logic                 w_skid_valid;
    logic [31:0]          w_skid_pc;
    logic                 w_skid_bd;
    logic [PAYLOAD_W-1:0] w_skid_payload;
    logic                 w_skid_clear;
    logic                 w_skid_load;
    logic                 w_skid_unload;

    assign w_in_ready    = ~w_skid_valid;
    assign w_skid_clear  = (w_action == ACT_REQ) || (w_action == ACT_CLR);
    assign w_skid_load   = (w_action == ACT_HOLD) && up.valid && w_in_ready;
    assign w_skid_unload = (w_action == ACT_LOAD) && w_skid_valid;

    pipe_skid_slot #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_skid_clear),
        .i_load    (w_skid_load),
        .i_unload  (w_skid_unload),
        .i_pc      (up.pc),
        .i_bd      (up.bd),
        .i_payload (up.payload),
        .o_valid   (w_skid_valid),
        .o_pc      (w_skid_pc),
        .o_bd      (w_skid_bd),
        .o_payload (w_skid_payload)
    );

    // An occupied skid slot is older than anything upstream, so it drains first.
    always_comb begin
        w_src_valid   = up.valid & w_in_ready;
        w_src_pc      = up.pc;
        w_src_bd      = up.bd;
        w_src_payload = up.payload;
        if (w_skid_valid) begin
            w_src_valid   = 1'b1;
            w_src_pc      = w_skid_pc;
            w_src_bd      = w_skid_bd;
            w_src_payload = w_skid_payload;
        end
    end
`else
    assign w_in_ready    = ~r_valid | dn.ready;
    assign w_src_valid   = up.valid;
    assign w_src_pc      = up.pc;
    assign w_src_bd      = up.bd;
    assign w_src_payload = up.payload;
`endif

    // Bubbles still carry PC/BD so a later exception can report the right EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_bd      <= 1'b0;
            r_payload <= '0;
        end else begin
            case (w_action)
                ACT_REQ: begin
                    r_valid   <= 1'b0;
                    r_pc      <= HANDLER_PC;
                    r_bd      <= 1'b0;
                    r_payload <= '0;
                end
                ACT_CLR: begin
                    r_valid   <= 1'b0;
                    r_pc      <= up.pc;
                    r_bd      <= up.bd;
                    r_payload <= '0;
                end
                ACT_LOAD: begin
                    r_valid   <= w_src_valid;
                    r_pc      <= w_src_pc;
                    r_bd      <= w_src_bd;
                    r_payload <= w_src_valid ? w_src_payload : '0;
                end
                default: begin
                    r_valid   <= r_valid;
                end
            endcase
        end
    end

    assign up.ready   = w_in_ready;
    assign dn.valid   = r_valid;
    assign dn.pc      = r_pc;
    assign dn.bd      = r_bd;
    assign dn.payload = r_payload;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for single-edge behaviour
// plus hand sequences for hold/skid, flush during hold and exception during hold.
module tb_pipe_stage_reg;
    import pipe_stage_pkg::*;

    localparam int PW = 16;

    typedef struct {
        logic            rst;
        logic            rq;
        logic            cl;
        logic            inValid;
        logic [31:0]     inPc;
        logic            inBd;
        logic [PW-1:0]   inPayload;
        logic            outReady;
        logic            expValid;
        logic [31:0]     expPc;
        logic            expBd;
        logic [PW-1:0]   expPayload;
    } vec_t;

    logic clk;
    logic reset;
    logic req;
    logic clr;
    int   checks;
    int   failures;

    pipe_stage_if #(.PAYLOAD_W(PW)) upIf ();
    pipe_stage_if #(.PAYLOAD_W(PW)) dnIf ();

    pipe_stage_reg #(
        .PAYLOAD_W  (PW),
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .clr   (clr),
        .up    (upIf),
        .dn    (dnIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic q, input logic c, input logic v,
                         input logic [31:0] pc, input logic bd, input logic [PW-1:0] pl,
                         input logic rdy);
        reset        = r;
        req          = q;
        clr          = c;
        upIf.valid   = v;
        upIf.pc      = pc;
        upIf.bd      = bd;
        upIf.payload = pl;
        dnIf.ready   = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.rst, v.rq, v.cl, v.inValid, v.inPc, v.inBd, v.inPayload, v.outReady);
        tick();
    endtask

    task automatic checkOutput(input string name, input logic expV, input logic [31:0] expPc,
                               input logic expBd, input logic [PW-1:0] expPl);
        checks++;
        if (dnIf.valid !== expV || dnIf.pc !== expPc || dnIf.bd !== expBd || dnIf.payload !== expPl) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b pc=%h bd=%b payload=%h, expected valid=%b pc=%h bd=%b payload=%h",
                     name, dnIf.valid, dnIf.pc, dnIf.bd, dnIf.payload, expV, expPc, expBd, expPl);
        end
    endtask

    task automatic checkReady(input string name, input logic expRdy);
        checks++;
        if (upIf.ready !== expRdy) begin
            failures++;
            $display("[TB] FAIL %s: got in_ready=%b, expected %b", name, upIf.ready, expRdy);
        end
    endtask

    initial begin
        vec_t        vecs[13];
        logic [31:0] seqPcs[2];
        logic [31:0] seqExpPc[5];
        logic        seqExpRdy[5];
        int          idx;

        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b1);

        // rst rq cl inV inPc bd payload rdy | expV expPc bd payload
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3010, 1'b0, 16'h00EE, 1'b1, 1'b0, 32'h3000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 16'h0011, 1'b1, 1'b1, 32'h3000, 1'b0, 16'h0011};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 1'b1, 16'h0022, 1'b1, 1'b1, 32'h3004, 1'b1, 16'h0022};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3008, 1'b0, 16'h0033, 1'b1, 1'b1, 32'h3008, 1'b0, 16'h0033};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h300C, 1'b1, 16'h0044, 1'b1, 1'b0, 32'h300C, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b1, 16'h0055, 1'b1, 1'b0, 32'h3020, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3024, 1'b1, 16'h0056, 1'b1, 1'b0, 32'h4180, 1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3028, 1'b1, 16'h0057, 1'b1, 1'b0, 32'h3000, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h302C, 1'b1, 16'h0058, 1'b1, 1'b0, 32'h4180, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3030, 1'b0, 16'h0066, 1'b0, 1'b1, 32'h3030, 1'b0, 16'h0066};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3034, 1'b1, 16'h0077, 1'b0, 1'b1, 32'h3030, 1'b0, 16'h0066};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h3040, 1'b0, 16'h0088, 1'b0, 1'b0, 32'h3040, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3044, 1'b0, 16'h0099, 1'b1, 1'b0, 32'h3044, 1'b0, 16'h0000};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expBd, vecs[i].expPayload);
        end

        // Hold sequence: upstream advances only when in_ready was expected high.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 16'h3000, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 1'b0, 16'h3004, 1'b1);
        tick();
        checkOutput("hold_prime", 1'b1, 32'h3004, 1'b0, 16'h3004);

        seqPcs[0]   = 32'h3008;
        seqPcs[1]   = 32'h300C;
        seqExpPc[0] = 32'h3004;
        seqExpPc[1] = 32'h3004;
        seqExpPc[2] = 32'h3004;
        seqExpPc[3] = 32'h3008;
        seqExpPc[4] = 32'h300C;
`ifdef PIPE_STAGE_SKID_EN
        seqExpRdy[0] = 1'b1;
        seqExpRdy[1] = 1'b0;
        seqExpRdy[2] = 1'b0;
        seqExpRdy[3] = 1'b0;
        seqExpRdy[4] = 1'b1;
`else
        seqExpRdy[0] = 1'b0;
        seqExpRdy[1] = 1'b0;
        seqExpRdy[2] = 1'b0;
        seqExpRdy[3] = 1'b1;
        seqExpRdy[4] = 1'b1;
`endif
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, seqPcs[idx], 1'b0, seqPcs[idx][15:0], c >= 3);
            #1;
            checkReady($sformatf("hold_rdy%0d", c), seqExpRdy[c]);
            if (seqExpRdy[c] && idx < 1)
                idx++;
            tick();
            checkOutput($sformatf("hold_out%0d", c), 1'b1, seqExpPc[c], 1'b0, seqExpPc[c][15:0]);
        end

        // req together with clr while holding: handler redirect, skid dropped.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3010, 1'b0, 16'h3010, 1'b0);
        tick();
        checkOutput("reqclr_hold", 1'b1, 32'h300C, 1'b0, 16'h300C);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h3014, 1'b1, 16'h3014, 1'b0);
        tick();
        checkOutput("reqclr_redirect", 1'b0, 32'h4180, 1'b0, 16'h0000);
        checkReady("reqclr_rdy", 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h3050, 1'b0, 16'h3050, 1'b0);
        tick();
        checkOutput("reqclr_skid_empty", 1'b0, 32'h3050, 1'b0, 16'h0000);

        // Flush while holding: bubble keeps the flushing PC/BD.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3060, 1'b0, 16'h3060, 1'b1);
        tick();
        checkOutput("clr_prime", 1'b1, 32'h3060, 1'b0, 16'h3060);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b1, 16'h3020, 1'b0);
        tick();
        checkOutput("clr_hold", 1'b0, 32'h3020, 1'b1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It is the successor to the fixed-field D/E register and is instantiated at the F/D, D/E, E/M and M/W boundaries. Control and data fields travel as one packed payload alongside an explicit valid bit, PC and branch-delay flag. It implements a valid/ready handshake, bubble insertion on flush, redirect to the exception handler on request, and an optional one-entry skid slot.

## Interface
- PAYLOAD_W, 128, width of the packed control/data payload (≥1)
- RESET_PC, 32'h0000_3000, out_pc value after reset
- HANDLER_PC, 32'h0000_4180, out_pc value after exception request
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- req  in  1  exception/interrupt taken; redirect bubble to handler
- clr  in  1  flush; insert bubble carrying in_pc/in_bd
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts an entry this cycle
- in_pc  in  32  upstream PC
- in_bd  in  1  upstream branch-delay flag
- in_payload  in  PAYLOAD_W  upstream packed fields
- out_valid  out  1  entry held is real (0 = bubble)
- out_ready  in  1  downstream consumes; `~out_ready` is the stall
- out_pc  out  32  held PC
- out_bd  out  1  held branch-delay flag
- out_payload  out  PAYLOAD_W  held fields

## Operation
- Priority per cycle: reset > req > clr > hold > load.
- reset: out_valid=0, out_payload=0, out_pc=RESET_PC, out_bd=0, skid empty.
- req: out_valid=0, out_payload=0, out_pc=HANDLER_PC, out_bd=0, skid emptied; in_ready ignored.
- clr: out_valid=0, out_payload=0, out_pc←in_pc, out_bd←in_bd (bubble keeps PC/BD so a later exception reports EPC correctly); skid emptied.
- Hold: out_valid=1 and out_ready=0 → all outputs unchanged.
- Load: out_valid=0 or out_ready=1 → outputs ← in_* when in_valid and in_ready; when in_valid=0 the stage becomes a bubble (out_valid=0, payload 0, pc/bd still loaded from in_pc/in_bd).
- Without skid: in_ready = ~out_valid | out_ready (combinational).
- A bubble (out_valid=0) is never held. out_ready is don't-care while out_valid=0.
- No width arithmetic: PC and payload pass through unmodified.

## Timing
- Latency: 1 cycle from in_* accept to out_*.
- Throughput: 1 entry/cycle when out_ready=1.
- req or clr asserted in the same cycle as reset: reset wins.
- req and clr asserted together: req wins.
- Hold is lost on clr/req: the held entry is discarded.
- reset, req and clr take effect on the edge where they are sampled high. No multi-cycle sequencing.

## Configuration
- PIPE_STAGE_SKID_EN defined: one-entry skid slot. in_ready = ~skid_valid (registered, no combinational path from out_ready). An entry accepted while the main register holds goes to the skid slot. On the next out_ready=1 edge the main register loads from the skid slot and the skid empties. reset, req and clr empty the skid. Per-edge capacity is 2 entries.
- Not defined: no skid slot; in_ready is combinational as above. This minimises area.

## Structure
- Package pipe_stage_pkg: RESET_PC_DEFAULT and HANDLER_PC_DEFAULT constants, plus per-boundary payload structs (de_payload_t, em_payload_t, ...) that are packed into in_payload, with their widths exported as localparams.
- Sub-module pipe_skid_slot (valid + pc + bd + payload register with load/clear), instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset with in_valid=1, in_pc=0x3010 → next edge: out_pc=0x3000, out_valid=0, out_payload=0, out_bd=0.
- Stream in_pc 0x3000, 0x3004, 0x3008 with out_ready=1 → out_pc follows one cycle later, out_valid=1 each cycle.
- out_ready=0 for 3 cycles with out_pc=0x3004 held → outputs are stable. No skid: in_ready=0. Skid: 0x3008 is captured, then in_ready=0. Release out_ready → 0x3004 is consumed, then 0x3008 is presented with no loss.
- clr with in_pc=0x3020, in_bd=1 → out_valid=0, out_payload=0, out_pc=0x3020, out_bd=1.
- req and clr together during a hold → out_pc=0x4180, out_bd=0, out_valid=0, skid empty.
- reset and req together → out_pc=0x3000.
